// File: rtl/tag_reg_file_pkg.sv
// Shared definitions for the tagged register file: default sizes, the
// "no producer" tag encoding and the register-entry layout.
package tag_reg_file_pkg;

  localparam int NREG_DEF   = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;
  localparam int NRD_DEF    = 2;
  localparam int NWB_DEF    = 2;

  // Tag value meaning "data is final, no producer in flight".
  localparam int unsigned TAG_INVALID = 0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [TAG_W_DEF-1:0]  tag;
  } reg_entry_t;

endpackage

// File: rtl/tag_reg_file_read_port.sv
// One registered read port: selects the stored entry or a same-cycle
// matching write-back (lowest write-back index wins), then holds it.
module rf_read_port
  import tag_reg_file_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NWB    = NWB_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [REG_W-1:0]      rd_reg,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic [TAG_W-1:0]      reg_tag,
  input  logic [NWB-1:0]        wb_match,
  input  logic [NWB*REG_W-1:0]  wb_reg,
  input  logic [NWB*DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0]     data,
  output logic [TAG_W-1:0]      tag
);

  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(TAG_INVALID);

  logic [DATA_W-1:0] data_d;
  logic [TAG_W-1:0]  tag_d;

  // Walk from the highest port down so the lowest matching index is applied last.
  always_comb begin
    data_d = reg_data;
    tag_d  = reg_tag;
    for (int k = NWB - 1; k >= 0; k--) begin
      if (wb_match[k] && (wb_reg[k*REG_W +: REG_W] == rd_reg)) begin
        data_d = wb_data[k*DATA_W +: DATA_W];
        tag_d  = TAG_INV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      tag  <= TAG_INV;
    end else if (en) begin
      data <= data_d;
      tag  <= tag_d;
    end
  end

endmodule

// File: rtl/tag_reg_file.sv
// Register file with per-register producer tags: rename via alloc, results
// retire via tag-matched write-back broadcast, flush clears all tags.
module tag_reg_file
  import tag_reg_file_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWB    = NWB_DEF,
  localparam int REG_W = $clog2(NREG),
  localparam int CNT_W = REG_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*REG_W-1:0]  rd_reg,
  output logic [NRD*TAG_W-1:0]  rd_tag,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  alloc_en,
  input  logic [REG_W-1:0]      alloc_reg,
  input  logic [TAG_W-1:0]      alloc_tag,
  input  logic [NWB-1:0]        wb_en,
  input  logic [NWB*REG_W-1:0]  wb_reg,
  input  logic [NWB*TAG_W-1:0]  wb_tag,
  input  logic [NWB*DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]      pending_cnt
);

  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(TAG_INVALID);

  logic [DATA_W-1:0] data_q [NREG];
  logic [TAG_W-1:0]  tag_q  [NREG];
  logic [DATA_W-1:0] data_d [NREG];
  logic [TAG_W-1:0]  tag_d  [NREG];

  logic [REG_W-1:0]  wb_reg_k  [NWB];
  logic [TAG_W-1:0]  wb_tag_k  [NWB];
  logic [DATA_W-1:0] wb_data_k [NWB];
  logic [NWB-1:0]    wb_match;
  logic [NWB-1:0]    wb_first;
  logic              alloc_ok;
  logic              alloc_new;
  logic [CNT_W-1:0]  n_clear;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // A write-back only matches a register that still awaits that exact tag;
  // register 0 never holds a tag, so it can never match.
  always_comb begin
    wb_match = '0;
    for (int k = 0; k < NWB; k++) begin
      wb_reg_k[k]  = wb_reg[k*REG_W +: REG_W];
      wb_tag_k[k]  = wb_tag[k*TAG_W +: TAG_W];
      wb_data_k[k] = wb_data[k*DATA_W +: DATA_W];
      wb_match[k]  = wb_en[k] && (wb_reg_k[k] != '0) &&
                     (tag_q[wb_reg_k[k]] != TAG_INV) &&
                     (tag_q[wb_reg_k[k]] == wb_tag_k[k]);
    end
  end

  // wb_first marks the winning port per register so duplicates count once.
  always_comb begin
    wb_first = wb_match;
    for (int k = 1; k < NWB; k++) begin
      for (int j = 0; j < k; j++) begin
        if (wb_match[j] && (wb_reg_k[j] == wb_reg_k[k])) wb_first[k] = 1'b0;
      end
    end
  end

  assign alloc_ok  = alloc_en && (alloc_tag != TAG_INV) && (alloc_reg != '0) && !flush;
  assign alloc_new = alloc_ok && (tag_q[alloc_reg] == TAG_INV);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      data_d[r] = data_q[r];
      tag_d[r]  = tag_q[r];
    end
    for (int k = NWB - 1; k >= 0; k--) begin
      if (wb_match[k]) begin
        data_d[wb_reg_k[k]] = wb_data_k[k];
        tag_d[wb_reg_k[k]]  = TAG_INV;
      end
    end
    if (alloc_ok) tag_d[alloc_reg] = alloc_tag;
    if (flush) begin
      for (int r = 0; r < NREG; r++) tag_d[r] = TAG_INV;
    end
    data_d[0] = '0;
    tag_d[0]  = TAG_INV;
  end

  // A write-back onto a register being re-allocated leaves it pending.
  always_comb begin
    n_clear = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_first[k] && !(alloc_ok && (wb_reg_k[k] == alloc_reg)))
        n_clear = n_clear + CNT_W'(1);
    end
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CNT_W'(alloc_new) - n_clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= TAG_INV;
      end
      cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
      cnt_q <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [REG_W-1:0] sel;
    assign sel = rd_reg[i*REG_W +: REG_W];

    rf_read_port #(
      .REG_W  (REG_W),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .NWB    (NWB)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .en       (rd_en[i]),
      .rd_reg   (sel),
      .reg_data (data_q[sel]),
      .reg_tag  (tag_q[sel]),
      .wb_match (wb_match),
      .wb_reg   (wb_reg),
      .wb_data  (wb_data),
      .data     (rd_data[i*DATA_W +: DATA_W]),
      .tag      (rd_tag[i*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_tag_reg_file.sv
// Scoreboard bench for tag_reg_file: expected read results are queued when a
// read is driven and compared one cycle later; pending_cnt checked directly.
module tb_tag_reg_file;

  localparam int NREG = 32, DW = 32, TW = 4, NRD = 2, NWB = 2;
  localparam int RW = 5, CW = 6;

  logic             clk = 1'b0;
  logic             rst, flush, alloc_en;
  logic [NRD-1:0]   rd_en;
  logic [NRD*RW-1:0] rd_reg;
  logic [NRD*TW-1:0] rd_tag;
  logic [NRD*DW-1:0] rd_data;
  logic [RW-1:0]    alloc_reg;
  logic [TW-1:0]    alloc_tag;
  logic [NWB-1:0]   wb_en;
  logic [NWB*RW-1:0] wb_reg;
  logic [NWB*TW-1:0] wb_tag;
  logic [NWB*DW-1:0] wb_data;
  logic [CW-1:0]    pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         port;
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  tag_reg_file #(.NREG(NREG), .DATA_W(DW), .TAG_W(TW), .NRD(NRD), .NWB(NWB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rd_en(rd_en), .rd_reg(rd_reg),
    .rd_tag(rd_tag), .rd_data(rd_data), .alloc_en(alloc_en), .alloc_reg(alloc_reg),
    .alloc_tag(alloc_tag), .wb_en(wb_en), .wb_reg(wb_reg), .wb_tag(wb_tag),
    .wb_data(wb_data), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; alloc_en = 0; alloc_reg = '0; alloc_tag = '0;
    rd_en = '0; rd_reg = '0; wb_en = '0; wb_reg = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic rd(input int p, input int r, input logic [31:0] ed, input logic [3:0] et);
    exp_t e;
    rd_en[p] = 1'b1;
    rd_reg[p*RW +: RW] = RW'(r);
    e.port = p; e.data = ed; e.tag = et;
    sb.push_back(e);
  endtask

  task automatic wb(input int p, input int r, input int t, input logic [31:0] d);
    wb_en[p] = 1'b1;
    wb_reg[p*RW +: RW] = RW'(r);
    wb_tag[p*TW +: TW] = TW'(t);
    wb_data[p*DW +: DW] = d;
  endtask

  task automatic alloc(input int r, input int t);
    alloc_en = 1'b1; alloc_reg = RW'(r); alloc_tag = TW'(t);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    clear_inputs();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val($sformatf("rd%0d_data", e.port), 64'(rd_data[e.port*DW +: DW]), 64'(e.data));
      check_val($sformatf("rd%0d_tag", e.port), 64'(rd_tag[e.port*TW +: TW]), 64'(e.tag));
    end
  endtask

  task automatic chk_cnt(input string name, input int exp);
    check_val(name, 64'(pending_cnt), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;

    // reset state
    rd(0, 5, 0, 0); rd(1, 5, 0, 0);
    tick();
    chk_cnt("cnt_reset", 0);

    // alloc, later matching write-back
    alloc(3, 7);                        tick(); chk_cnt("cnt_alloc_r3", 1);
                                        tick(); chk_cnt("cnt_wait_r3", 1);
    wb(0, 3, 7, 32'hDEADBEEF);          tick(); chk_cnt("cnt_wb_r3", 0);
    rd(0, 3, 32'hDEADBEEF, 0);          tick();

    // stale write-back dropped
    alloc(4, 2);                        tick(); chk_cnt("cnt_alloc_r4a", 1);
    alloc(4, 9);                        tick(); chk_cnt("cnt_alloc_r4b", 1);
    wb(0, 4, 2, 32'h11);                tick(); chk_cnt("cnt_stale", 1);
    rd(1, 4, 0, 9);                     tick();

    // read bypass
    alloc(6, 5);                        tick(); chk_cnt("cnt_alloc_r6", 2);
    rd(0, 6, 32'h55, 0); wb(1, 6, 5, 32'h55); tick(); chk_cnt("cnt_bypass", 1);
    rd(1, 6, 32'h55, 0);                tick();

    // read + alloc + write-back on one register
    alloc(6, 4);                        tick(); chk_cnt("cnt_alloc_r6b", 2);
    rd(0, 6, 32'h77, 0); wb(0, 6, 4, 32'h77); alloc(6, 3); tick();
    chk_cnt("cnt_rd_alloc_wb", 2);
    rd(0, 6, 32'h77, 3);                tick();

    // lowest write-back index wins, counted once
    alloc(7, 6);                        tick(); chk_cnt("cnt_alloc_r7", 3);
    wb(0, 7, 6, 32'hA0); wb(1, 7, 6, 32'hB0); rd(1, 7, 32'hA0, 0); tick();
    chk_cnt("cnt_dual_wb", 2);
    rd(0, 7, 32'hA0, 0);                tick();

    // rd_en low holds outputs
    tick();
    check_val("hold_data", 64'(rd_data[0 +: DW]), 64'h0A0);
    check_val("hold_tag",  64'(rd_tag[0 +: TW]), 64'h0);

    // alloc r1..r8, then flush with write-back, suppressed alloc and a read
    for (int r = 1; r <= 8; r++) begin
      alloc(r, r);
      tick();
    end
    chk_cnt("cnt_alloc8", 8);
    flush = 1'b1; wb(0, 2, 2, 32'hAA); alloc(9, 5); rd(0, 4, 0, 4);
    tick();
    chk_cnt("cnt_flush", 0);
    rd(0, 2, 32'hAA, 0); rd(1, 3, 32'hDEADBEEF, 0); tick();
    rd(0, 6, 32'h77, 0); rd(1, 7, 32'hA0, 0);       tick();
    rd(0, 9, 0, 0);      rd(1, 1, 0, 0);             tick();
    chk_cnt("cnt_after_flush", 0);

    // register 0 ignores alloc and write-back
    alloc(0, 5); wb(0, 0, 5, 32'hFF);   tick(); chk_cnt("cnt_r0", 0);
    rd(0, 0, 0, 0);                     tick();

    // alloc with the invalid tag is no alloc
    alloc(10, 0);                       tick(); chk_cnt("cnt_inv_alloc", 0);
    rd(1, 10, 0, 0);                    tick();

    // reset overrides everything in the same cycle
    alloc(5, 3);                        tick(); chk_cnt("cnt_pre_rst", 1);
    rst = 1'b1; flush = 1'b1; alloc(11, 2); wb(0, 5, 3, 32'h99);
    rd_en = 2'b11; rd_reg = {5'd3, 5'd2};
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;
    chk_cnt("cnt_rst", 0);
    check_val("rst_rd0_data", 64'(rd_data[0 +: DW]), 64'h0);
    check_val("rst_rd1_tag",  64'(rd_tag[TW +: TW]), 64'h0);
    rd(0, 3, 0, 0); rd(1, 5, 0, 0);     tick();
    rd(0, 11, 0, 0); rd(1, 2, 0, 0);    tick();
    chk_cnt("cnt_post_rst", 0);

    check_val("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_reg_file.md
TAG_REG_FILE -- requirements
Module: tag_reg_file

Interface
REQ-001 SHALL take parameter NREG, default 32, as the number of architectural registers (power of two).
REQ-002 SHALL take parameter DATA_W, default 32, as the register data width.
REQ-003 SHALL take parameter TAG_W, default 4, as the in-flight instruction tag width.
REQ-004 SHALL take parameter NRD, default 2, as the number of source read ports.
REQ-005 SHALL take parameter NWB, default 2, as the number of write-back ports.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port flush, input, 1 bit: clear all pending tags (misprediction recovery).
REQ-009 SHALL have port rd_en, input, [NRD]: per-port read request.
REQ-010 SHALL have port rd_reg, input, [NRD] x log2(NREG): source register numbers.
REQ-011 SHALL have port rd_tag, output, [NRD] x TAG_W: registered producer tag, TAG_INVALID when data is final.
REQ-012 SHALL have port rd_data, output, [NRD] x DATA_W: registered register value.
REQ-013 SHALL have port alloc_en, input, 1 bit: rename request.
REQ-014 SHALL have port alloc_reg, input, log2(NREG): destination register.
REQ-015 SHALL have port alloc_tag, input, TAG_W: new producer tag.
REQ-016 SHALL have ports wb_en, wb_reg, wb_tag and wb_data, inputs, [NWB] x (1, log2(NREG), TAG_W, DATA_W): result broadcast.
REQ-017 SHALL have port pending_cnt, output, log2(NREG)+1: count of registers holding a non-invalid tag.

Function
REQ-018 SHALL give each register a data field and a tag field; register 0 SHALL always read data 0 and tag TAG_INVALID, and SHALL ignore alloc and write-back.
REQ-019 Read latency SHALL be 1 cycle; when rd_en[i]=0, rd_tag[i] and rd_data[i] SHALL hold their previous values.
REQ-020 Write-back port k SHALL update register r when wb_en[k]=1, wb_reg[k]=r and regs[r].tag==wb_tag[k]: data<=wb_data[k], tag<=TAG_INVALID; on tag mismatch the write SHALL be dropped (stale result).
REQ-021 If several write-back ports match the same register in one cycle, the lowest index SHALL win.
REQ-022 Read bypass: if a read in cycle N targets a register that a write-back matches in cycle N, the port SHALL return wb_data with TAG_INVALID at N+1.
REQ-023 Alloc SHALL set regs[alloc_reg].tag<=alloc_tag; a read of the same register in the same cycle SHALL return the pre-alloc tag/data (reads precede rename).
REQ-024 Alloc and a matching write-back to the same register in one cycle: data SHALL be written, and the tag SHALL become alloc_tag (alloc wins for the tag).
REQ-025 Read, alloc and write-back on the same register in one cycle: the read SHALL return bypassed data with TAG_INVALID.
REQ-026 flush SHALL set every tag to TAG_INVALID at the next edge, preserve all data, honour same-cycle write-back data, and suppress same-cycle alloc; reads in the flush cycle SHALL behave as without flush.
REQ-027 pending_cnt SHALL be a registered counter updated each cycle by (+1 alloc on a previously invalid tag) − (matching write-backs clearing a tag), and SHALL be forced to 0 on flush; it SHALL never exceed NREG−1.
REQ-028 alloc_tag==TAG_INVALID SHALL be treated as no alloc.

Reset
REQ-029 On rst, all data SHALL become 0, all tags TAG_INVALID, rd_data 0, rd_tag TAG_INVALID and pending_cnt 0, with rst overriding flush, alloc, write-back and reads in the same cycle.

Structure
REQ-030 TAG_INVALID, the default parameter values and the register-entry struct (data, tag) SHALL live in the shared common package.
REQ-031 Per-read-port bypass/priority selection SHALL be one sub-module, rf_read_port, instantiated NRD times.

Verification
REQ-032 Reset, then read r5 on both ports -> next cycle data 0, tag TAG_INVALID, pending_cnt 0.
REQ-033 Alloc r3 tag 7; wb r3 tag 7 data 0xDEADBEEF two cycles later; read r3 -> 0xDEADBEEF, TAG_INVALID; pending_cnt goes 1 then 0.
REQ-034 Alloc r4 tag 2, then alloc r4 tag 9; wb r4 tag 2 data 0x11 -> dropped, read returns old data with tag 9.
REQ-035 Same cycle: read r6, wb r6 matching tag data 0x55 -> rd_data 0x55, TAG_INVALID next cycle; same case plus alloc r6 tag 3 -> read still 0x55/INVALID and a later read shows tag 3.
REQ-036 Alloc r1..r8 with tags 1..8, then assert flush with wb r2 tag 2 data 0xAA -> all tags invalid, r2=0xAA, others unchanged, pending_cnt 0.
REQ-037 Alloc r0 tag 5 and wb r0 data 0xFF -> r0 reads 0 with TAG_INVALID, pending_cnt unchanged.
